decryption_cfg_arbiter: RTL



---
 rtl/decryption_cfg_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/decryption_cfg_arbiter.sv
// Round-robin arbiter sharing the decryption register file port
// between the host config bus (m0) and the key-loading sequencer (m1).
module decryption_cfg_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int REG_WIDTH  = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_valid,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [REG_WIDTH-1:0]  m0_wdata,
    output logic                  m0_ack,
    output logic [REG_WIDTH-1:0]  m0_rdata,
    output logic                  m0_error,
    input  logic                  m1_valid,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [REG_WIDTH-1:0]  m1_wdata,
    output logic                  m1_ack,
    output logic [REG_WIDTH-1:0]  m1_rdata,
    output logic                  m1_error,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic                  rf_read,
    output logic                  rf_write,
    output logic [REG_WIDTH-1:0]  rf_wdata,
    input  logic [REG_WIDTH-1:0]  rf_rdata,
    input  logic                  rf_done,
    input  logic                  rf_error,
    output logic                  busy,
    output logic                  grant
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    prio_q;
    logic                    prio_d;
    logic                    we_q;
    logic                    we_d;
    logic                    grant_d;
    logic                    sel;
    logic [TW-1:0]           timer_q;
    logic [TW-1:0]           timer_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [REG_WIDTH-1:0]    wdata_d;
    logic                    rd_d;
    logic                    wr_d;
    logic                    fin;
    logic                    fin_err;
    logic [REG_WIDTH-1:0]    fin_data;

    // State register; a reset drops any in-flight transaction silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, arbitration and response selection.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        we_d     = we_q;
        grant_d  = grant;
        addr_d   = rf_addr;
        wdata_d  = rf_wdata;
        timer_d  = timer_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        sel      = 1'b0;
        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_data = '0;
        unique case (state_q)
            IDLE: begin
                // With both pending the pointer decides, otherwise
                // whichever one is asking.
                sel = (m0_valid && m1_valid) ? prio_q : m1_valid;
                if (m0_valid || m1_valid) begin
                    grant_d = sel;
                    we_d    = sel ? m1_we : m0_we;
                    addr_d  = sel ? m1_addr : m0_addr;
                    wdata_d = sel ? m1_wdata : m0_wdata;
                    wr_d    = we_d;
                    rd_d    = !we_d;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                if (rf_done) begin
                    fin      = 1'b1;
                    fin_err  = rf_error;
                    fin_data = we_q ? '0 : rf_rdata;
                    state_d  = RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                prio_d  = ~grant;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered datapath, strobes and per-requester responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q   <= 1'b0;
            we_q     <= 1'b0;
            grant    <= 1'b0;
            busy     <= 1'b0;
            timer_q  <= '0;
            rf_addr  <= '0;
            rf_wdata <= '0;
            rf_read  <= 1'b0;
            rf_write <= 1'b0;
            m0_ack   <= 1'b0;
            m0_rdata <= '0;
            m0_error <= 1'b0;
            m1_ack   <= 1'b0;
            m1_rdata <= '0;
            m1_error <= 1'b0;
        end else begin
            prio_q   <= prio_d;
            we_q     <= we_d;
            grant    <= grant_d;
            busy     <= (state_d != IDLE);
            timer_q  <= timer_d;
            rf_addr  <= addr_d;
            rf_wdata <= wdata_d;
            rf_read  <= rd_d;
            rf_write <= wr_d;
            m0_ack   <= fin & ~grant;
            m0_rdata <= (fin && !grant) ? fin_data : '0;
            m0_error <= fin & ~grant & fin_err;
            m1_ack   <= fin & grant;
            m1_rdata <= (fin && grant) ? fin_data : '0;
            m1_error <= fin & grant & fin_err;
        end
    end

endmodule
